// File: rtl/frogger_pkg.sv
// Frogger parameters shared by the movement, rendering and collision logic.
package frogger_pkg;

  localparam int GRID_W_DEF        = 10;
  localparam int GRID_H_DEF        = 15;
  localparam int START_X_DEF       = 4;
  localparam int START_Y_DEF       = 14;
  localparam int REPEAT_DELAY_DEF  = 12_500_000;
  localparam int REPEAT_PERIOD_DEF = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } move_state_e;

  // Bit positions in the packed switch vector {Right, Left, Down, Up}.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Up > Down > Left > Right when several switches rise together.
  function automatic dir_e pick_dir(input logic [3:0] rise);
    if (rise[0]) return DIR_UP;
    if (rise[1]) return DIR_DOWN;
    if (rise[2]) return DIR_LEFT;
    return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/frog_repeat_timer.sv
// Hold / auto-repeat timer: counts up from zero while enabled and flags the
// terminal count for either the initial delay or the repeat period.
module frog_repeat_timer
  import frogger_pkg::*;
#(
  parameter int DELAY  = REPEAT_DELAY_DEF,
  parameter int PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Select_Period,
  input  logic i_Enable,
  output logic o_Terminal
);

  localparam int CW = $clog2(max_int(DELAY, PERIOD) + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit;

  assign limit      = i_Select_Period ? CW'(PERIOD - 1) : CW'(DELAY - 1);
  assign o_Terminal = i_Enable && (cnt_q == limit);

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear) begin
      cnt_d = '0;
    end else if (i_Enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frog_move_ctrl.sv
// Frog movement controller: turns the four direction switches into single
// moves with hold-to-repeat, clamps at the playfield edges and flags a win.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a rising edge on any direction switch
//   ST_HOLD   | latched direction held, waiting for the first auto-repeat
//   ST_REPEAT | latched direction still held, moving every repeat period
module frog_move_ctrl
  import frogger_pkg::*;
#(
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF,
  parameter int START_X       = START_X_DEF,
  parameter int START_Y       = START_Y_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Up,
  input  logic          i_Down,
  input  logic          i_Left,
  input  logic          i_Right,
  input  logic          i_Enable,
  input  logic          i_Frog_Reset,
  output logic [XW-1:0] o_Frog_X,
  output logic [YW-1:0] o_Frog_Y,
  output logic          o_Move_Pulse,
  output logic          o_Win
);

  logic [3:0]    sw_cur, prev_q, rise;
  move_state_e   state_q, state_d;
  dir_e          dir_q, dir_d, move_dir;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pulse_q, pulse_d;
  logic          win_q, win_d;
  logic          move_req, held;
  logic          tmr_clear, tmr_sel, tmr_en, tmr_tc;

  assign sw_cur = {i_Right, i_Left, i_Down, i_Up};
  assign rise   = sw_cur & ~prev_q;
  assign held   = sw_cur[dir_q];

  frog_repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .i_Clk           (i_Clk),
    .i_Rst_L         (i_Rst_L),
    .i_Clear         (tmr_clear),
    .i_Select_Period (tmr_sel),
    .i_Enable        (tmr_en),
    .o_Terminal      (tmr_tc)
  );

  // Next state, timer control and move arithmetic with edge clamping.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    x_d       = x_q;
    y_d       = y_q;
    pulse_d   = 1'b0;
    win_d     = 1'b0;
    move_req  = 1'b0;
    move_dir  = dir_q;
    tmr_clear = 1'b0;
    tmr_en    = (state_q != ST_IDLE);
    tmr_sel   = (state_q == ST_REPEAT);

    if (i_Frog_Reset) begin
      x_d       = XW'(START_X);
      y_d       = YW'(START_Y);
      state_d   = ST_IDLE;
      tmr_clear = 1'b1;
    end else if (!i_Enable) begin
      state_d   = ST_IDLE;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tmr_clear = 1'b1;
          if (|rise) begin
            move_req = 1'b1;
            move_dir = pick_dir(rise);
            dir_d    = move_dir;
            state_d  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!held) begin
            state_d   = ST_IDLE;
            tmr_clear = 1'b1;
          end else if (tmr_tc) begin
            move_req  = 1'b1;
            tmr_clear = 1'b1;
            state_d   = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (!held) begin
            state_d   = ST_IDLE;
            tmr_clear = 1'b1;
          end else if (tmr_tc) begin
            move_req  = 1'b1;
            tmr_clear = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          tmr_clear = 1'b1;
        end
      endcase
    end

    // A blocked move still advances the FSM; it just produces no strobe.
    if (move_req) begin
      unique case (move_dir)
        DIR_UP: begin
          if (y_q != '0) begin
            y_d     = y_q - YW'(1);
            pulse_d = 1'b1;
          end
        end
        DIR_DOWN: begin
          if (y_q != YW'(GRID_H - 1)) begin
            y_d     = y_q + YW'(1);
            pulse_d = 1'b1;
          end
        end
        DIR_LEFT: begin
          if (x_q != '0) begin
            x_d     = x_q - XW'(1);
            pulse_d = 1'b1;
          end
        end
        DIR_RIGHT: begin
          if (x_q != XW'(GRID_W - 1)) begin
            x_d     = x_q + XW'(1);
            pulse_d = 1'b1;
          end
        end
      endcase
      win_d = pulse_d && (y_d == '0);
    end
  end

  // State, position, strobes and previous switch levels.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      x_q     <= XW'(START_X);
      y_q     <= YW'(START_Y);
      pulse_q <= 1'b0;
      win_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pulse_q <= pulse_d;
      win_q   <= win_d;
      prev_q  <= sw_cur;
    end
  end

  assign o_Frog_X     = x_q;
  assign o_Frog_Y     = y_q;
  assign o_Move_Pulse = pulse_q;
  assign o_Win        = win_q;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Scoreboard bench for frog_move_ctrl with a short repeat delay/period.
module tb_frog_move_ctrl;

  localparam int GW  = 10;
  localparam int GH  = 15;
  localparam int SX  = 4;
  localparam int SY  = 14;
  localparam int DLY = 8;
  localparam int PER = 3;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n, up, down, left, right, en, frog_rst;
  logic [3:0] x, y;
  logic       pulse, win;

  typedef struct {
    int x;
    int y;
    bit win;
  } exp_t;

  exp_t exp_q[$];
  int   mx, my;
  int   checks = 0;
  int   passes = 0;

  frog_move_ctrl #(
    .GRID_W        (GW),
    .GRID_H        (GH),
    .START_X       (SX),
    .START_Y       (SY),
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Up         (up),
    .i_Down       (down),
    .i_Left       (left),
    .i_Right      (right),
    .i_Enable     (en),
    .i_Frog_Reset (frog_rst),
    .o_Frog_X     (x),
    .o_Frog_Y     (y),
    .o_Move_Pulse (pulse),
    .o_Win        (win)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Edge index k (1 = first clock that sees the press) produces a move?
  function automatic bit move_at(input int k);
    return (k == 1) || (k >= 1 + DLY && ((k - 1 - DLY) % PER) == 0);
  endfunction

  function automatic void model_move(input int d);
    int nx = mx;
    int ny = my;
    case (d)
      0:       ny = my - 1;
      1:       ny = my + 1;
      2:       nx = mx - 1;
      default: nx = mx + 1;
    endcase
    if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
      mx = nx;
      my = ny;
      exp_q.push_back('{mx, my, bit'(my == 0)});
    end
  endfunction

  function automatic int top_dir(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0 Up, 1 Down, 2 Left, 3 Right
  task automatic drive(input logic [3:0] m);
    {right, left, down, up} = m;
  endtask

  task automatic press(input logic [3:0] m, input int n, input int gap);
    int d = top_dir(m);
    for (int k = 1; k <= n; k++) if (move_at(k)) model_move(d);
    drive(m);
    repeat (n) step();
    drive(4'b0000);
    repeat (gap) step();
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: every move strobe must match the oldest expected move.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pulse) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", int'(pulse), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("move_x", int'(x), e.x);
          check("move_y", int'(y), e.y);
          check("move_win", int'(win), int'(e.win));
        end
      end else if (win) begin
        check("win_without_move", int'(win), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; frog_rst = 1'b0;
    drive(4'b0000);
    mx = SX; my = SY;

    repeat (3) @(negedge clk);
    check("reset_x", int'(x), SX);
    check("reset_y", int'(y), SY);
    check("reset_pulse", int'(pulse), 0);
    check("reset_win", int'(win), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // single Up press
    check("pre_up_y", int'(y), 14);
    press(4'b0001, 1, 3);
    check("up_x", int'(x), 4);
    check("up_y", int'(y), 13);

    // Right held: 1, 9, 12, 15, 18 move, 21 blocked at the edge
    press(4'b1000, 25, 3);
    check("right_hold_x", int'(x), 9);

    // Up and Left together: Up wins
    press(4'b0101, 1, 2);
    check("up_left_x", int'(x), 9);
    check("up_left_y", int'(y), 12);

    // climb to row 1, then the winning move
    while (my > 1) press(4'b0001, 1, 1);
    press(4'b0001, 1, 2);
    check("win_row_y", int'(y), 0);

    // frog reset in REPEAT, coinciding with a repeat terminal count
    drive(4'b0010);
    for (int k = 1; k <= 14; k++) if (move_at(k)) model_move(1);
    repeat (14) step();
    frog_rst = 1'b1;
    step();
    frog_rst = 1'b0;
    mx = SX; my = SY;
    check("frog_reset_x", int'(x), SX);
    check("frog_reset_y", int'(y), SY);
    repeat (15) step();
    drive(4'b0000);
    repeat (2) step();
    check("down_held_queue", exp_q.size(), 0);
    press(4'b0010, 1, 2);

    // Up held through frog reset must not move again until re-pressed
    drive(4'b0001);
    model_move(0);
    repeat (3) step();
    frog_rst = 1'b1;
    step();
    frog_rst = 1'b0;
    mx = SX; my = SY;
    repeat (15) step();
    check("held_through_reset_y", int'(y), SY);
    drive(4'b0000);
    repeat (2) step();
    check("held_through_reset_queue", exp_q.size(), 0);
    press(4'b0001, 1, 2);
    check("repress_y", int'(y), 13);

    // disabled: press is tracked but ignored, and stays ignored once enabled
    en = 1'b0;
    drive(4'b1000);
    repeat (5) step();
    en = 1'b1;
    repeat (12) step();
    drive(4'b0000);
    repeat (2) step();
    check("disabled_x", int'(x), mx);
    check("disabled_y", int'(y), my);

    // randomized presses
    for (int i = 0; i < 40; i++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      press(m, int'($urandom_range(1, 20)), int'($urandom_range(1, 3)));
    end
    check("random_x", int'(x), mx);
    check("random_y", int'(y), my);

    // async reset mid-REPEAT with the clock stopped
    frog_rst = 1'b1;
    step();
    frog_rst = 1'b0;
    mx = SX; my = SY;
    drive(4'b1000);
    for (int k = 1; k <= 12; k++) if (move_at(k)) model_move(3);
    repeat (12) step();
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_x", int'(x), SX);
    check("async_y", int'(y), SY);
    check("async_pulse", int'(pulse), 0);
    check("async_win", int'(win), 0);
    #20;
    rst_n = 1'b1;
    #2;
    mx = SX; my = SY;
    model_move(3);
    clk_run = 1'b1;
    repeat (3) step();
    drive(4'b0000);
    repeat (2) step();
    check("post_reset_queue", exp_q.size(), 0);
    check("post_reset_x", int'(x), SX + 1);

    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
